instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
- Consumer side of the program counter: reads the registered PC and fetches the instruction at that address.
- Issues one read per fetch to instruction memory over a valid/ready request channel, then waits on a valid-only response channel.
- Holds the fetched word in an instruction register with a valid/ready handshake toward the microsequencer/decoder.
- Non-pipelined: at most one fetch outstanding.

Parameters:
- NOP_INSTR, 32'h0000_0013, value loaded into instr on reset, misalignment or timeout (ADDI x0,x0,0).
- TIMEOUT_CYCLES, 16, WAIT-state cycles before a timeout fault; used only with IFETCH_TIMEOUT_EN; legal range 2..255.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- pc  input  32  current PC from the program counter register
- fetch_req  input  1  start fetch; sampled only in IDLE
- flush  input  1  synchronous abort of the current fetch
- fetch_busy  output  1  high when state != IDLE or drop_pending
- mem_req_valid  output  1  memory read request valid
- mem_req_ready  input  1  memory accepts request
- mem_req_addr  output  32  read address, word-aligned
- mem_rsp_valid  input  1  response valid, single-cycle pulse
- mem_rsp_data  input  32  read data
- mem_rsp_err  input  1  bus error qualifier for the response
- instr  output  32  instruction register
- instr_pc  output  32  address of instr
- instr_valid  output  1  instr/instr_pc/fault valid
- instr_ready  input  1  consumer accepts instr
- fault  output  1  fetch faulted; qualified by instr_valid
- fault_cause  output  2  00 none, 01 misaligned, 10 bus error, 11 timeout

Behaviour:
- Reset (async): state=IDLE, mem_req_valid=0, mem_req_addr=0, instr=NOP_INSTR, instr_pc=0, instr_valid=0, fault=0, fault_cause=00, drop_pending=0, timeout counter=0.
- States: IDLE, REQ, WAIT, HOLD. All outputs registered.
- IDLE:
  - fetch_req=1 and drop_pending=0: mem_req_addr<=pc.
  - If pc[1:0]!=00: go to HOLD with instr=NOP_INSTR, instr_pc=pc, fault=1, cause=01. No memory request.
  - Else: go to REQ with mem_req_valid<=1.
  - fetch_req while fetch_busy=1 is ignored (no queuing).
- REQ:
  - mem_req_valid and mem_req_addr are held stable until mem_req_ready=1.
  - On handshake: go to WAIT; mem_req_valid=0 from the next cycle.
  - mem_rsp_valid in REQ is a protocol violation and is ignored.
- WAIT: on mem_rsp_valid, go to HOLD with instr=mem_rsp_data, instr_pc=mem_req_addr, instr_valid=1, fault=mem_rsp_err, cause=10 if error else 00. Data is captured even when mem_rsp_err=1.
- HOLD:
  - instr, instr_pc, fault and fault_cause are stable while instr_valid=1.
  - On instr_ready=1: go to IDLE, instr_valid=0 next cycle. instr keeps its last value.
  - A new fetch_req is sampled no earlier than the next cycle.
- Minimum latency: fetch_req at cycle 0 -> mem_req_valid at cycle 1 -> (ready at cycle 1) WAIT at cycle 2 -> (rsp at cycle 2) instr_valid at cycle 3.
- Flush (synchronous, any state):
  - Next cycle: state=IDLE, mem_req_valid=0, instr_valid=0.
  - If a request has been accepted but its response not yet received (state WAIT, or REQ with mem_req_ready=1 in the same cycle), set drop_pending=1.
  - The next mem_rsp_valid while drop_pending=1 is discarded and clears drop_pending.
  - fetch_req is ignored while drop_pending=1.
  - flush has priority over every other event, including instr_ready and mem_rsp_valid in the same cycle.
- Response in the same cycle as flush while in WAIT: the response is discarded and drop_pending is not set.
- rst mid-operation: immediate return to reset values. Any memory response still in flight after reset is the memory's responsibility; the block ignores responses in IDLE.

Optional Feature:
- Macro: IFETCH_TIMEOUT_EN.
- Defined:
  - 8-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When the counter reaches TIMEOUT_CYCLES with no response: go to HOLD with instr=NOP_INSTR, instr_pc=mem_req_addr, fault=1, cause=11, and set drop_pending=1 so the late response is discarded.
  - Response in the timeout cycle: the response wins.
- Undefined:
  - No counter logic; WAIT waits indefinitely.
  - cause 11 is never produced.

Test Plan:
- Reset, then pc=0x0000_0040, fetch_req pulse, ready=1, rsp one cycle later with data=0x0010_0093 -> instr_valid at cycle 3, instr=0x0010_0093, instr_pc=0x40, fault=0.
- pc=0x0000_0042, fetch_req -> no mem_req_valid ever; instr_valid next cycle, instr=0x0000_0013, fault=1, cause=01.
- mem_req_ready low for 4 cycles -> mem_req_valid and addr held stable; response with mem_rsp_err=1 -> fault=1, cause=10, instr=rsp data.
- Flush in WAIT, then fetch_req (ignored, fetch_busy=1), stale rsp arrives, then new fetch at pc=0x44 -> stale data never appears on instr; instr_pc=0x44 delivered.
- instr_ready held low 5 cycles in HOLD, with fetch_req toggling -> outputs stable, no new mem request. Assert rst mid-WAIT -> all outputs at reset values the same cycle.
- With IFETCH_TIMEOUT_EN, TIMEOUT_CYCLES=16, no rsp -> instr_valid 16 cycles after entering WAIT, cause=11; late rsp dropped.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read channel: valid/ready request, valid-only response.
// master = fetch unit, slave = instruction memory.
interface instr_fetch_unit_if;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        mem_rsp_err;

  modport master (
    output mem_req_valid, mem_req_addr,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err
  );

  modport slave (
    input  mem_req_valid, mem_req_addr,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Non-pipelined instruction fetch: one read per fetch_req, result held in an
// instruction register. Define IFETCH_TIMEOUT_EN to enable the WAIT-state timeout.
module instr_fetch_unit #(
  parameter logic [31:0] NOP_INSTR      = 32'h0000_0013,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               pc,
  input  logic                      fetch_req,
  input  logic                      flush,
  output logic                      fetch_busy,
  instr_fetch_unit_if.master        mem,
  output logic [31:0]               instr,
  output logic [31:0]               instr_pc,
  output logic                      instr_valid,
  input  logic                      instr_ready,
  output logic                      fault,
  output logic [1:0]                fault_cause
);

  // state  | meaning
  // IDLE   | no fetch in progress, fetch_req sampled here
  // REQ    | read request presented, waiting for mem_req_ready
  // WAIT   | request accepted, waiting for mem_rsp_valid
  // HOLD   | instr/fault valid, waiting for instr_ready
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_MISALGN = 2'b01;
  localparam logic [1:0] CAUSE_BUS     = 2'b10;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("instr_fetch_unit: TIMEOUT_CYCLES out of range 2..255");
  end

  logic [1:0]  state;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        drop_pending;

`ifdef IFETCH_TIMEOUT_EN
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;
  localparam logic [7:0] TO_LIMIT      = 8'(TIMEOUT_CYCLES);
  logic [7:0] to_cnt;
`endif

  assign mem.mem_req_valid = req_valid;
  assign mem.mem_req_addr  = req_addr;
  assign fetch_busy        = (state != S_IDLE) || drop_pending;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      req_valid    <= 1'b0;
      req_addr     <= 32'd0;
      instr        <= NOP_INSTR;
      instr_pc     <= 32'd0;
      instr_valid  <= 1'b0;
      fault        <= 1'b0;
      fault_cause  <= CAUSE_NONE;
      drop_pending <= 1'b0;
`ifdef IFETCH_TIMEOUT_EN
      to_cnt       <= 8'd0;
`endif
    end else if (flush) begin
      state       <= S_IDLE;
      req_valid   <= 1'b0;
      instr_valid <= 1'b0;
      // an accepted read whose response is still outstanding must be swallowed later
      if ((state == S_WAIT && !mem.mem_rsp_valid) || (state == S_REQ && mem.mem_req_ready))
        drop_pending <= 1'b1;
      else if (mem.mem_rsp_valid)
        drop_pending <= 1'b0;
    end else begin
      if (drop_pending && mem.mem_rsp_valid)
        drop_pending <= 1'b0;
      case (state)
        S_IDLE: begin
          if (fetch_req && !drop_pending) begin
            req_addr <= pc;
            if (pc[1:0] != 2'b00) begin
              state       <= S_HOLD;
              instr       <= NOP_INSTR;
              instr_pc    <= pc;
              instr_valid <= 1'b1;
              fault       <= 1'b1;
              fault_cause <= CAUSE_MISALGN;
            end else begin
              state     <= S_REQ;
              req_valid <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (mem.mem_req_ready) begin
            state     <= S_WAIT;
            req_valid <= 1'b0;
`ifdef IFETCH_TIMEOUT_EN
            to_cnt    <= 8'd0;
`endif
          end
        end
        S_WAIT: begin
`ifdef IFETCH_TIMEOUT_EN
          to_cnt <= to_cnt + 8'd1;
`endif
          if (mem.mem_rsp_valid) begin
            state       <= S_HOLD;
            instr       <= mem.mem_rsp_data;
            instr_pc    <= req_addr;
            instr_valid <= 1'b1;
            fault       <= mem.mem_rsp_err;
            fault_cause <= mem.mem_rsp_err ? CAUSE_BUS : CAUSE_NONE;
          end
`ifdef IFETCH_TIMEOUT_EN
          else if (to_cnt + 8'd1 == TO_LIMIT) begin
            state        <= S_HOLD;
            instr        <= NOP_INSTR;
            instr_pc     <= req_addr;
            instr_valid  <= 1'b1;
            fault        <= 1'b1;
            fault_cause  <= CAUSE_TIMEOUT;
            drop_pending <= 1'b1;
          end
`endif
        end
        S_HOLD: begin
          if (instr_ready) begin
            state       <= S_IDLE;
            instr_valid <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
